collatz_sweep_ctrl: RTL

Sequencer that sweeps a range of Collatz start values through an external single-step Collatz datapath. For each start value it iterates the step until the value reaches 1, overflows, or hits a step cap. It tracks the start value with the longest orbit and counts overflowed starts. It sits between the host I/O register file and the combinational step core, so a whole range runs without per-value host interaction.

---
 rtl/collatz_sweep_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/collatz_sweep_ctrl.sv
// collatz_sweep_ctrl: sweeps a range of Collatz start values through an
// external combinational step core. It records the start value with the
// longest orbit and counts the starts that overflowed or hit the step cap.
module collatz_sweep_ctrl #(
    parameter int unsigned BITS      = 64,
    parameter int unsigned OLEN_BITS = 16,
    parameter int unsigned CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [BITS-1:0]      base,
    input  logic [CNT_BITS-1:0]  count,
    input  logic                 abort,
    output logic [BITS-1:0]      core_iter,
    input  logic [BITS-1:0]      core_next,
    input  logic                 core_ovf,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [BITS-1:0]      best_start,
    output logic [OLEN_BITS-1:0] best_len,
    output logic [BITS-1:0]      cur_start,
    output logic [CNT_BITS-1:0]  ovf_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_RECORD,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [BITS-1:0]      iter;
    logic [OLEN_BITS-1:0] len;
    logic [CNT_BITS-1:0]  remaining;
    logic                 valid;
    logic                 accept;
    logic                 iter_is_one;
    logic                 len_capped;

    // In IDLE a simultaneous abort suppresses the start request.
    assign accept      = (state == S_IDLE) && start && !abort;
    assign iter_is_one = (iter == BITS'(1));
    assign len_capped  = (len == '1);

    assign core_iter = iter;
    assign busy      = (state == S_LOAD) || (state == S_RUN) || (state == S_RECORD);
    assign done      = (state == S_DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state selection; abort overrides everything while a sweep is active.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) state_next = (count == '0) ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                if (abort)                 state_next = S_DONE;
                else if (cur_start == '0)  state_next = S_RECORD;
                else                       state_next = S_RUN;
            end
            S_RUN: begin
                if (abort)                                   state_next = S_DONE;
                else if (iter_is_one || core_ovf || len_capped) state_next = S_RECORD;
            end
            S_RECORD: begin
                if (abort)                          state_next = S_DONE;
                else if (remaining == CNT_BITS'(1)) state_next = S_DONE;
                else                                state_next = S_LOAD;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Sweep datapath: iterate, orbit length, best tracking and overflow count.
    always_ff @(posedge clk) begin
        if (reset) begin
            iter       <= '0;
            len        <= '0;
            remaining  <= '0;
            valid      <= 1'b0;
            cur_start  <= '0;
            best_start <= '0;
            best_len   <= '0;
            ovf_count  <= '0;
            aborted    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cur_start  <= base;
                        remaining  <= count;
                        best_start <= '0;
                        best_len   <= '0;
                        ovf_count  <= '0;
                        aborted    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        aborted <= 1'b1;
                    end else begin
                        iter  <= cur_start;
                        len   <= '0;
                        valid <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        aborted <= 1'b1;
                    end else if (iter_is_one) begin
                        valid <= 1'b1;
                    end else if (core_ovf || len_capped) begin
                        valid <= 1'b0;
                        if (ovf_count != '1) ovf_count <= ovf_count + CNT_BITS'(1);
                    end else begin
                        iter <= core_next;
                        len  <= len + OLEN_BITS'(1);
                    end
                end
                S_RECORD: begin
                    if (abort) begin
                        aborted <= 1'b1;
                    end else begin
                        if (valid && (len > best_len)) begin
                            best_start <= cur_start;
                            best_len   <= len;
                        end
                        remaining <= remaining - CNT_BITS'(1);
                        cur_start <= cur_start + BITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
